// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial front end, MSB first, with a
// one-word holding buffer so back-to-back words stream gap-free.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   DataIn     in   WIDTH-bit word, sampled on accept
//   InValid    in   upstream offers DataIn
//   InReady    out  holding buffer free (registered)
//   SerOut     out  serial bit, IDLE_BIT when nothing shifts
//   SerValid   out  SerOut carries a data bit
//   FrameStart out  SerOut carries a word MSB
//   Busy       out  shifter or holding buffer occupied
module byte_serializer #(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] DataIn,
   input  logic             InValid,
   output logic             InReady,
   output logic             SerOut,
   output logic             SerValid,
   output logic             FrameStart,
   output logic             Busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] hold_q,  hold_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             fs_q,    fs_d;
   logic             accept;

   // Ready comes only from registered buffer state.
   assign accept = InValid && !hold_full_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         fs_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         fs_q        <= fs_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;
      fs_d        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_SHIFT;
               shreg_d = DataIn;
               cnt_d   = CNT_TOP;
               fs_d    = 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q != '0) begin
               shreg_d = shreg_q << 1;
               cnt_d   = cnt_q - 1'b1;
               if (accept) begin
                  hold_d      = DataIn;
                  hold_full_d = 1'b1;
               end
            end else if (hold_full_q) begin
               // LSB cycle: buffered word follows
               // with no idle gap.
               shreg_d     = hold_q;
               cnt_d       = CNT_TOP;
               hold_full_d = 1'b0;
               fs_d        = 1'b1;
            end else if (accept) begin
               // Word arriving in the LSB cycle
               // bypasses the buffer.
               shreg_d = DataIn;
               cnt_d   = CNT_TOP;
               fs_d    = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign SerValid   = (state_q == S_SHIFT);
   assign SerOut     = SerValid ? shreg_q[WIDTH-1] : IDLE_BIT;
   assign FrameStart = fs_q;
   assign Busy       = SerValid || hold_full_q;
   assign InReady    = !hold_full_q;

endmodule
